// File: rtl/regfile_wb_arbiter_if.sv
// Interface bundling the write-port requests, decode scoreboard queries and
// register-file write signals of the writeback arbiter.
interface regfile_wb_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int REG_BITS = 5
);
  logic                a_valid;
  logic [REG_BITS-1:0] a_reg;
  logic [WIDTH-1:0]    a_data;
  logic                b_valid;
  logic [REG_BITS-1:0] b_reg;
  logic [WIDTH-1:0]    b_data;
  logic                b_ready;
  logic                mark_en;
  logic [REG_BITS-1:0] mark_reg;
  logic [REG_BITS-1:0] rs1;
  logic [REG_BITS-1:0] rs2;
  logic                rs1_busy;
  logic                rs2_busy;
  logic                rd_busy;
  logic                sb_empty;
  logic                wb_hold;
  logic                rf_we;
  logic [REG_BITS-1:0] rf_waddr;
  logic [WIDTH-1:0]    rf_wdata;

  // Requesters, decode and the register file side.
  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    output mark_en, mark_reg, rs1, rs2,
    input  b_ready, rs1_busy, rs2_busy, rd_busy, sb_empty, wb_hold,
    input  rf_we, rf_waddr, rf_wdata
  );

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
    input  mark_en, mark_reg, rs1, rs2,
    output b_ready, rs1_busy, rs2_busy, rd_busy, sb_empty, wb_hold,
    output rf_we, rf_waddr, rf_wdata
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: writeback stage (A) has fixed priority,
// long-latency unit (B) is tracked by a busy scoreboard and starvation counter.
module regfile_wb_arbiter #(
  parameter int WIDTH        = 32,
  parameter int REG_COUNT    = 32,
  parameter int REG_BITS     = $clog2(REG_COUNT),
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rstn,
  regfile_wb_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [REG_COUNT-1:0] busy_q, busy_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 a_req;
  logic                 b_acc;
  logic                 b_wr;

  // Writes to x0 never occupy the port, so they cannot block B.
  assign a_req       = bus.a_valid && (bus.a_reg != '0);
  assign bus.b_ready = rstn && !a_req;
  assign b_acc       = bus.b_valid && bus.b_ready;
  assign b_wr        = b_acc && (bus.b_reg != '0);

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    if (rstn && a_req) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.a_reg;
      bus.rf_wdata = bus.a_data;
    end else if (b_wr) begin
      bus.rf_we    = 1'b1;
      bus.rf_waddr = bus.b_reg;
      bus.rf_wdata = bus.b_data;
    end
  end

  // Per-register next state; a set in the same cycle as a clear wins.
  assign busy_d[0] = 1'b0;
  for (genvar gi = 1; gi < REG_COUNT; gi++) begin : g_busy
    logic set_hit, clr_hit;
    assign set_hit    = bus.mark_en && (bus.mark_reg == REG_BITS'(gi));
    assign clr_hit    = b_acc && (bus.b_reg == REG_BITS'(gi));
    assign busy_d[gi] = set_hit || (busy_q[gi] && !clr_hit);
  end

  always_comb begin
    cnt_d = 4'd0;
    if (bus.b_valid && !bus.b_ready)
      cnt_d = (cnt_q == LIMIT) ? LIMIT : cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.rs1_busy = busy_q[bus.rs1];
  assign bus.rs2_busy = busy_q[bus.rs2];
  assign bus.rd_busy  = busy_q[bus.mark_reg];
  assign bus.sb_empty = (busy_q == '0);
  assign bus.wb_hold  = (cnt_q == LIMIT);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed vector table plus multi-cycle sequences and a random phase, all
// checked against hand values and a small behavioural model.
module tb_regfile_wb_arbiter;
  localparam int WIDTH = 32;
  localparam int RB    = 5;
  localparam int LIM   = 4;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.WIDTH(WIDTH), .REG_BITS(RB)) bus ();

  regfile_wb_arbiter #(.WIDTH(WIDTH), .REG_COUNT(32), .REG_BITS(RB), .STARVE_LIMIT(LIM)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] m_busy = '0;
  int          m_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bready();
    return rstn && !(bus.a_valid && bus.a_reg != 0);
  endfunction

  // Wait for mid-cycle and compare every output against the model.
  task automatic cyc_start();
    logic           we;
    logic [RB-1:0]  wa;
    logic [31:0]    wd;
    @(negedge clk);
    we = 1'b0; wa = '0; wd = '0;
    if (rstn && bus.a_valid && bus.a_reg != 0) begin
      we = 1'b1; wa = bus.a_reg; wd = bus.a_data;
    end else if (rstn && bus.b_valid && bus.b_reg != 0 && exp_bready()) begin
      we = 1'b1; wa = bus.b_reg; wd = bus.b_data;
    end
    chk("m_rf_we", bus.rf_we, we);
    chk("m_rf_waddr", bus.rf_waddr, wa);
    chk("m_rf_wdata", bus.rf_wdata, wd);
    chk("m_b_ready", bus.b_ready, exp_bready());
    chk("m_wb_hold", bus.wb_hold, m_cnt == LIM);
    chk("m_sb_empty", bus.sb_empty, m_busy == 0);
    chk("m_rs1_busy", bus.rs1_busy, m_busy[bus.rs1]);
    chk("m_rs2_busy", bus.rs2_busy, m_busy[bus.rs2]);
    chk("m_rd_busy", bus.rd_busy, m_busy[bus.mark_reg]);
  endtask

  task automatic cyc_end();
    if (rstn) begin
      if (bus.b_valid && exp_bready()) m_busy[bus.b_reg] = 1'b0;
      if (bus.mark_en && bus.mark_reg != 0) m_busy[bus.mark_reg] = 1'b1;
      if (bus.b_valid && !exp_bready()) m_cnt = (m_cnt == LIM) ? LIM : m_cnt + 1;
      else m_cnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid = 0; bus.a_reg = 0; bus.a_data = 0;
    bus.b_valid = 0; bus.b_reg = 0; bus.b_data = 0;
    bus.mark_en = 0; bus.mark_reg = 0; bus.rs1 = 0; bus.rs2 = 0;
  endtask

  typedef struct {
    logic          av; logic [RB-1:0] ar; logic [31:0] ad;
    logic          bv; logic [RB-1:0] br; logic [31:0] bd;
    logic          we; logic [RB-1:0] wa; logic [31:0] wd; logic rdy;
  } vec_t;

  vec_t vt[9];

  initial begin
    vt[0] = '{0, 0,  0,            0, 0,  0,            0, 0,  0,            1};
    vt[1] = '{1, 3,  32'h11,       0, 0,  0,            1, 3,  32'h11,       0};
    vt[2] = '{1, 3,  32'h11,       1, 7,  32'h22,       1, 3,  32'h11,       0};
    vt[3] = '{0, 0,  0,            1, 7,  32'h22,       1, 7,  32'h22,       1};
    vt[4] = '{1, 0,  32'h44,       1, 9,  32'h99,       1, 9,  32'h99,       1};
    vt[5] = '{0, 0,  0,            1, 0,  32'h77,       0, 0,  0,            1};
    vt[6] = '{1, 0,  32'h55,       0, 0,  0,            0, 0,  0,            1};
    vt[7] = '{1, 31, 32'hdeadbeef, 1, 0,  32'h66,       1, 31, 32'hdeadbeef, 0};
    vt[8] = '{0, 0,  0,            1, 31, 32'hcafef00d, 1, 31, 32'hcafef00d, 1};

    idle();
    #2 rstn = 1'b0;
    #2;
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_b_ready", bus.b_ready, 0);
    chk("rst_wb_hold", bus.wb_hold, 0);
    chk("rst_sb_empty", bus.sb_empty, 1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      bus.a_valid = vt[i].av; bus.a_reg = vt[i].ar; bus.a_data = vt[i].ad;
      bus.b_valid = vt[i].bv; bus.b_reg = vt[i].br; bus.b_data = vt[i].bd;
      cyc_start();
      chk($sformatf("vec%0d_we", i), bus.rf_we, vt[i].we);
      chk($sformatf("vec%0d_waddr", i), bus.rf_waddr, vt[i].wa);
      chk($sformatf("vec%0d_wdata", i), bus.rf_wdata, vt[i].wd);
      chk($sformatf("vec%0d_ready", i), bus.b_ready, vt[i].rdy);
      cyc_end();
    end

    // Marking x0 never makes the scoreboard non-empty.
    idle(); bus.mark_en = 1; bus.mark_reg = 0;
    cyc_start(); cyc_end();
    idle(); cyc_start(); chk("x0_mark_empty", bus.sb_empty, 1); cyc_end();

    // Scoreboard set, visible-next-cycle clear, and set-beats-clear.
    bus.mark_en = 1; bus.mark_reg = 12;
    cyc_start(); chk("sb_set_same_cycle", bus.sb_empty, 1); cyc_end();
    idle(); bus.rs1 = 12; bus.rs2 = 12; bus.mark_reg = 12;
    cyc_start();
    chk("sb_rs1_busy", bus.rs1_busy, 1);
    chk("sb_rs2_busy", bus.rs2_busy, 1);
    chk("sb_rd_busy", bus.rd_busy, 1);
    chk("sb_not_empty", bus.sb_empty, 0);
    cyc_end();
    bus.b_valid = 1; bus.b_reg = 12; bus.b_data = 32'h1234;
    cyc_start(); chk("sb_commit_cycle_busy", bus.rs1_busy, 1); chk("sb_commit_waddr", bus.rf_waddr, 12); cyc_end();
    bus.b_valid = 0;
    cyc_start(); chk("sb_cleared", bus.rs1_busy, 0); chk("sb_empty_again", bus.sb_empty, 1); cyc_end();
    bus.mark_en = 1;
    cyc_start(); cyc_end();
    bus.b_valid = 1; bus.b_data = 32'h5678;
    cyc_start(); cyc_end();
    bus.mark_en = 0; bus.b_valid = 0;
    cyc_start(); chk("sb_set_wins", bus.rs1_busy, 1); cyc_end();
    bus.b_valid = 1;
    cyc_start(); cyc_end();
    idle(); cyc_start(); chk("sb_final_empty", bus.sb_empty, 1); cyc_end();

    // Starvation: B loses six cycles, then gets the port.
    bus.b_valid = 1; bus.b_reg = 20; bus.b_data = 32'hb0b0;
    bus.a_valid = 1; bus.a_reg = 1; bus.a_data = 32'ha0a0;
    for (int c = 1; c <= 6; c++) begin
      cyc_start();
      chk($sformatf("starve_c%0d_hold", c), bus.wb_hold, c >= 5);
      chk($sformatf("starve_c%0d_waddr", c), bus.rf_waddr, 1);
      cyc_end();
    end
    bus.a_valid = 0;
    cyc_start();
    chk("starve_c7_hold", bus.wb_hold, 1);
    chk("starve_c7_waddr", bus.rf_waddr, 20);
    chk("starve_c7_ready", bus.b_ready, 1);
    cyc_end();
    bus.b_valid = 0;
    cyc_start(); chk("starve_c8_hold", bus.wb_hold, 0); cyc_end();

    // Asynchronous reset in the middle of activity.
    idle(); bus.mark_en = 1; bus.mark_reg = 5;
    cyc_start(); cyc_end();
    idle(); bus.a_valid = 1; bus.a_reg = 3; bus.b_valid = 1; bus.b_reg = 6;
    repeat (3) begin cyc_start(); cyc_end(); end
    bus.rs1 = 5;
    #2 rstn = 1'b0;
    #1;
    m_busy = '0; m_cnt = 0;
    chk("arst_sb_empty", bus.sb_empty, 1);
    chk("arst_wb_hold", bus.wb_hold, 0);
    chk("arst_rf_we", bus.rf_we, 0);
    chk("arst_b_ready", bus.b_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b1; idle(); bus.rs1 = 5;
    cyc_start(); chk("arst_rs1_busy", bus.rs1_busy, 0); cyc_end();

    // Random traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      bus.a_valid  = ($urandom_range(0, 3) == 0);
      bus.a_reg    = RB'($urandom_range(0, 31));
      bus.a_data   = $urandom;
      bus.b_valid  = $urandom_range(0, 1);
      bus.b_reg    = RB'($urandom_range(0, 31));
      bus.b_data   = $urandom;
      bus.mark_en  = ($urandom_range(0, 2) == 0);
      bus.mark_reg = RB'($urandom_range(0, 31));
      bus.rs1      = RB'($urandom_range(0, 31));
      bus.rs2      = RB'($urandom_range(0, 31));
      cyc_start();
      cyc_end();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
